// File: rtl/controle_ponto_flt_pkg.sv
// Shared types and constants for the floating-point multiply/divide sequencer.
// Optional statistics build macro: PONTO_FLT_ESTAT_EN (used in controle_ponto_flt.sv).
package pkg_ponto_flt;

  typedef enum logic [2:0] {
    OCIOSO,
    CARREGA,
    INICIA,
    ESPERA,
    RESPONDE
  } estado_t;

  typedef enum logic [1:0] {
    ZERO,
    NORMAL,
    INF,
    NAN
  } classe_t;

  localparam logic [31:0] NAN_CANONICO = 32'h7FC0_0000;
  localparam logic [31:0] INF_POS      = 32'h7F80_0000;

  // Bit positions inside the 3-bit {timeout, div_zero, invalido} flag word
  localparam int unsigned FLAG_INVALIDO = 0;
  localparam int unsigned FLAG_DIV_ZERO = 1;
  localparam int unsigned FLAG_TIMEOUT  = 2;

  // Denormals (exponent field 0) are flushed into the ZERO class
  function automatic classe_t classifica(input logic [31:0] v);
    classe_t c;
    if (v[30:23] == 8'h00) begin
      c = ZERO;
    end else if (v[30:23] == 8'hFF) begin
      c = (v[22:0] == 23'd0) ? INF : NAN;
    end else begin
      c = NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/controle_ponto_flt_if.sv
// Core-side request/response channels of the floating-point sequencer.
// master = core (issues requests, consumes responses), slave = controller.
interface controle_ponto_flt_if #(
  parameter int unsigned TAG_W = 4
);

  logic             req_valid;
  logic             req_ready;
  logic             req_mul;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;

  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_dado;
  logic [TAG_W-1:0] resp_tag;
  logic [2:0]       resp_flags;

  modport master (
    output req_valid, req_mul, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_dado, resp_tag, resp_flags
  );

  modport slave (
    input  req_valid, req_mul, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_dado, resp_tag, resp_flags
  );

endinterface

// File: rtl/controle_ponto_flt_classifica_especial.sv
// Combinational IEEE special-operand resolver: decides whether an operation
// can be answered without the datapath and, if so, what the answer is.
module classifica_especial
  import pkg_ponto_flt::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mul,
  output logic        is_especial,
  output logic [31:0] resultado,
  output logic [2:0]  flags
);

  classe_t     ca;
  classe_t     cb;
  logic [31:0] zero_sinal;
  logic [31:0] inf_sinal;

  assign ca         = classifica(a);
  assign cb         = classifica(b);
  assign zero_sinal = {a[31] ^ b[31], 31'd0};
  assign inf_sinal  = INF_POS | zero_sinal;

  // Priority: NaN inputs first, then the indeterminate forms, then inf/zero
  always_comb begin
    is_especial = 1'b0;
    resultado   = 32'd0;
    flags       = 3'b000;
    if (ca == NAN || cb == NAN) begin
      is_especial            = 1'b1;
      resultado              = NAN_CANONICO;
      flags[FLAG_INVALIDO]   = 1'b1;
    end else if (mul) begin
      if ((ca == ZERO && cb == INF) || (ca == INF && cb == ZERO)) begin
        is_especial          = 1'b1;
        resultado            = NAN_CANONICO;
        flags[FLAG_INVALIDO] = 1'b1;
      end else if (ca == INF || cb == INF) begin
        is_especial          = 1'b1;
        resultado            = inf_sinal;
      end else if (ca == ZERO || cb == ZERO) begin
        is_especial          = 1'b1;
        resultado            = zero_sinal;
      end
    end else begin
      if ((ca == ZERO && cb == ZERO) || (ca == INF && cb == INF)) begin
        is_especial          = 1'b1;
        resultado            = NAN_CANONICO;
        flags[FLAG_INVALIDO] = 1'b1;
      end else if (ca == NORMAL && cb == ZERO) begin
        is_especial          = 1'b1;
        resultado            = inf_sinal;
        flags[FLAG_DIV_ZERO] = 1'b1;
      end else if (ca == ZERO || cb == INF) begin
        is_especial          = 1'b1;
        resultado            = zero_sinal;
      end else if (ca == INF) begin
        // inf/0 and inf/x both land here
        is_especial          = 1'b1;
        resultado            = inf_sinal;
      end
    end
  end

endmodule

// File: rtl/controle_ponto_flt.sv
// Sequencer for the floating-point multiply/divide datapath: accepts one
// operation, loads and starts the datapath (or resolves special operands
// locally), waits for finish with a timeout and returns the result.
// Optional macro PONTO_FLT_ESTAT_EN adds saturating response/timeout counters.
module controle_ponto_flt
  import pkg_ponto_flt::*;
#(
  parameter int unsigned TAG_W          = 4,
  parameter int unsigned TIMEOUT_CICLOS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  controle_ponto_flt_if.slave bus,
  output logic [31:0]         fpu_a,
  output logic [31:0]         fpu_b,
  output logic                fpu_multiplicando,
  output logic                fpu_start,
  input  logic [31:0]         fpu_s,
  input  logic                fpu_finish
`ifdef PONTO_FLT_ESTAT_EN
  ,
  output logic [15:0]         estat_ops,
  output logic [15:0]         estat_timeouts
`endif
);

  // Last ESPERA cycle count before giving up
  localparam logic [7:0] LIMITE = 8'(TIMEOUT_CICLOS - 1);

  estado_t          estado_q, estado_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [31:0]      dado_q, dado_d;
  logic [2:0]       flags_q, flags_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic             mul_q, mul_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             req_ready;
  logic             aceita;
  logic             evento_timeout;
  logic             entrega;

  logic             esp_is;
  logic [31:0]      esp_res;
  logic [2:0]       esp_flags;

  classifica_especial u_classifica (
    .a           (bus.req_a),
    .b           (bus.req_b),
    .mul         (bus.req_mul),
    .is_especial (esp_is),
    .resultado   (esp_res),
    .flags       (esp_flags)
  );

  // Held low while reset is asserted even though the state already reads OCIOSO
  assign req_ready = rst_n && (estado_q == OCIOSO);
  assign aceita    = bus.req_valid && req_ready;
  assign entrega   = (estado_q == RESPONDE) && bus.resp_ready;

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = (estado_q == RESPONDE);
  assign bus.resp_dado  = dado_q;
  assign bus.resp_tag   = tag_q;
  assign bus.resp_flags = flags_q;

  assign fpu_a             = a_q;
  assign fpu_b             = b_q;
  assign fpu_multiplicando = mul_q;
  assign fpu_start         = (estado_q == INICIA);

  // Next-state and result/operand capture
  always_comb begin
    estado_d       = estado_q;
    cnt_d          = cnt_q;
    dado_d         = dado_q;
    flags_d        = flags_q;
    a_d            = a_q;
    b_d            = b_q;
    mul_d          = mul_q;
    tag_d          = tag_q;
    evento_timeout = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (aceita) begin
          a_d   = bus.req_a;
          b_d   = bus.req_b;
          mul_d = bus.req_mul;
          tag_d = bus.req_tag;
          if (esp_is) begin
            dado_d   = esp_res;
            flags_d  = esp_flags;
            estado_d = RESPONDE;
          end else begin
            estado_d = CARREGA;
          end
        end
      end
      CARREGA: estado_d = INICIA;
      INICIA: begin
        cnt_d    = 8'd0;
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (fpu_finish) begin
          dado_d   = fpu_s;
          flags_d  = 3'b000;
          estado_d = RESPONDE;
        end else if (cnt_q == LIMITE) begin
          dado_d                = NAN_CANONICO;
          flags_d               = 3'b000;
          flags_d[FLAG_TIMEOUT] = 1'b1;
          evento_timeout        = 1'b1;
          estado_d              = RESPONDE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESPONDE: begin
        if (bus.resp_ready) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // State and datapath-facing registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      cnt_q    <= 8'd0;
      dado_q   <= 32'd0;
      flags_q  <= 3'b000;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      mul_q    <= 1'b0;
      tag_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      dado_q   <= dado_d;
      flags_q  <= flags_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mul_q    <= mul_d;
      tag_q    <= tag_d;
    end
  end

`ifdef PONTO_FLT_ESTAT_EN
  logic [15:0] ops_q, tmo_q;

  // Saturating counters of delivered responses and timeouts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q <= 16'd0;
      tmo_q <= 16'd0;
    end else begin
      if (entrega && ops_q != 16'hFFFF) ops_q <= ops_q + 16'd1;
      if (evento_timeout && tmo_q != 16'hFFFF) tmo_q <= tmo_q + 16'd1;
    end
  end

  assign estat_ops      = ops_q;
  assign estat_timeouts = tmo_q;
`else
  logic unused_estat;
  assign unused_estat = entrega ^ evento_timeout;
`endif

endmodule

// File: tb/tb_controle_ponto_flt.sv
// Directed bench for controle_ponto_flt with a small datapath model whose
// latency, result and "never finishes" behaviour are set per step.
module tb_controle_ponto_flt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fpu_a, fpu_b, fpu_s;
  logic        fpu_multiplicando, fpu_start, fpu_finish;
`ifdef PONTO_FLT_ESTAT_EN
  logic [15:0] estat_ops, estat_timeouts;
`endif

  controle_ponto_flt_if #(.TAG_W(4)) bus ();

  controle_ponto_flt #(.TAG_W(4), .TIMEOUT_CICLOS(64)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bus               (bus),
    .fpu_a             (fpu_a),
    .fpu_b             (fpu_b),
    .fpu_multiplicando (fpu_multiplicando),
    .fpu_start         (fpu_start),
    .fpu_s             (fpu_s),
    .fpu_finish        (fpu_finish)
`ifdef PONTO_FLT_ESTAT_EN
    ,
    .estat_ops         (estat_ops),
    .estat_timeouts    (estat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int start_cyc = -1;

  // Datapath model
  int          fpu_lat = 4;
  logic        fpu_hang = 1'b0;
  logic [31:0] fpu_res = 32'd0;
  logic        model_fin;
  logic        finish_inj = 1'b0;
  logic        model_busy;
  int          model_cnt;

  assign fpu_s      = fpu_res;
  assign fpu_finish = model_fin | finish_inj;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_busy <= 1'b0;
      model_fin  <= 1'b0;
      model_cnt  <= 0;
    end else begin
      model_fin <= 1'b0;
      if (fpu_start) begin
        model_busy <= !fpu_hang;
        model_cnt  <= 1;
      end else if (model_busy) begin
        if (model_cnt == fpu_lat) begin
          model_fin  <= 1'b1;
          model_busy <= 1'b0;
        end else begin
          model_cnt <= model_cnt + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fpu_start) begin
      n_start   <= n_start + 1;
      start_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pedir(input logic mul, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
    bus.req_valid = 1'b1;
    bus.req_mul   = mul;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
  endtask

  task automatic wait_resp(input int lim, output int c);
    int n;
    n = 0;
    while (!bus.resp_valid && n < lim) begin
      tick();
      n++;
    end
    c = cyc;
    chk("resp_chega", 32'(bus.resp_valid), 32'd1);
  endtask

  task automatic consome();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    int t, c, ns, visto;
    logic instavel;
    bus.req_valid  = 1'b0;
    bus.req_mul    = 1'b0;
    bus.req_a      = 32'd0;
    bus.req_b      = 32'd0;
    bus.req_tag    = 4'd0;
    bus.resp_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_dado", bus.resp_dado, 32'd0);
    chk("rst_flags", 32'(bus.resp_flags), 32'd0);
    chk("rst_fpu_start", 32'(fpu_start), 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("pos_rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Normal multiply: 2.0 * 3.0 = 6.0, finish 5 cycles after start
    fpu_lat = 4;
    fpu_res = 32'h40C0_0000;
    ns = n_start;
    t = cyc;
    pedir(1'b1, 32'h4000_0000, 32'h4040_0000, 4'd5);
    tick();
    bus.req_valid = 1'b0;
    chk("mul_fpu_a", fpu_a, 32'h4000_0000);
    chk("mul_fpu_b", fpu_b, 32'h4040_0000);
    chk("mul_multiplicando", 32'(fpu_multiplicando), 32'd1);
    chk("mul_start_cedo", 32'(fpu_start), 32'd0);
    tick();
    chk("mul_start_t2", 32'(fpu_start), 32'd1);
    wait_resp(50, c);
    chk("mul_lat_resp", 32'(c - t), 32'd8);
    chk("mul_start_ciclo", 32'(start_cyc - t), 32'd2);
    chk("mul_n_start", 32'(n_start - ns), 32'd1);
    chk("mul_dado", bus.resp_dado, 32'h40C0_0000);
    chk("mul_flags", 32'(bus.resp_flags), 32'd0);
    chk("mul_tag", 32'(bus.resp_tag), 32'd5);
    consome();
    chk("mul_resp_baixa", 32'(bus.resp_valid), 32'd0);
    chk("mul_req_ready", 32'(bus.req_ready), 32'd1);

    // 1.0 / 0 -> +inf, div_zero, no datapath use
    ns = n_start;
    pedir(1'b0, 32'h3F80_0000, 32'h0000_0000, 4'd3);
    tick();
    bus.req_valid = 1'b0;
    chk("div0_resp_t1", 32'(bus.resp_valid), 32'd1);
    chk("div0_dado", bus.resp_dado, 32'h7F80_0000);
    chk("div0_flags", 32'(bus.resp_flags), 32'b010);
    chk("div0_tag", 32'(bus.resp_tag), 32'd3);
    consome();
    chk("div0_sem_start", 32'(n_start - ns), 32'd0);

    // -0 * inf -> NaN invalid, then back-to-back -2 / inf -> -0
    pedir(1'b1, 32'h8000_0000, 32'h7F80_0000, 4'd6);
    tick();
    bus.req_valid = 1'b0;
    chk("zinf_dado", bus.resp_dado, 32'h7FC0_0000);
    chk("zinf_flags", 32'(bus.resp_flags), 32'b001);
    bus.resp_ready = 1'b1;
    pedir(1'b0, 32'hC000_0000, 32'h7F80_0000, 4'd7);
    tick();
    bus.resp_ready = 1'b0;
    chk("b2b_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("ndivinf_valid", 32'(bus.resp_valid), 32'd1);
    chk("ndivinf_dado", bus.resp_dado, 32'h8000_0000);
    chk("ndivinf_flags", 32'(bus.resp_flags), 32'd0);
    chk("ndivinf_tag", 32'(bus.resp_tag), 32'd7);
    consome();

    // Datapath hangs -> timeout after 64 ESPERA cycles; late finish ignored
    fpu_hang = 1'b1;
    t = cyc;
    pedir(1'b1, 32'h3F80_0000, 32'h4000_0000, 4'd8);
    tick();
    bus.req_valid = 1'b0;
    wait_resp(200, c);
    chk("tmo_lat", 32'(c - t), 32'd67);
    chk("tmo_dado", bus.resp_dado, 32'h7FC0_0000);
    chk("tmo_flags", 32'(bus.resp_flags), 32'b100);
    chk("tmo_tag", 32'(bus.resp_tag), 32'd8);
    consome();
    fpu_hang = 1'b0;
    finish_inj = 1'b1;
    tick();
    finish_inj = 1'b0;
    visto = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.resp_valid) visto++;
      tick();
    end
    chk("tmo_sem_segunda", 32'(visto), 32'd0);

    // Backpressure: response must hold for 10 cycles, no new accept
    fpu_lat = 4;
    fpu_res = 32'h3F80_0000;
    pedir(1'b1, 32'h3F80_0000, 32'h3F80_0000, 4'd9);
    tick();
    pedir(1'b1, 32'h0000_0000, 32'h4000_0000, 4'hA);
    bus.req_valid = 1'b0;
    wait_resp(50, c);
    bus.req_valid = 1'b1;
    instavel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.resp_valid || bus.req_ready || bus.resp_dado != 32'h3F80_0000 ||
          bus.resp_tag != 4'd9 || bus.resp_flags != 3'b000) instavel = 1'b1;
    end
    chk("bp_estavel", 32'(instavel), 32'd0);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("bp_ready_apos", 32'(bus.req_ready), 32'd1);
    chk("bp_valid_baixa", 32'(bus.resp_valid), 32'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("bp_novo_valid", 32'(bus.resp_valid), 32'd1);
    chk("bp_novo_dado", bus.resp_dado, 32'h0000_0000);
    chk("bp_novo_tag", 32'(bus.resp_tag), 32'hA);
    consome();

    // Reset in ESPERA abandons the operation
    fpu_lat = 20;
    pedir(1'b0, 32'h4000_0000, 32'h4000_0000, 4'd2);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rstm_start", 32'(fpu_start), 32'd0);
    chk("rstm_valid", 32'(bus.resp_valid), 32'd0);
    chk("rstm_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    fpu_lat = 4;
    fpu_res = 32'h4100_0000;
    t = cyc;
    pedir(1'b1, 32'h4000_0000, 32'h4080_0000, 4'd4);
    tick();
    bus.req_valid = 1'b0;
    wait_resp(50, c);
    chk("rstm_lat", 32'(c - t), 32'd8);
    chk("rstm_dado", bus.resp_dado, 32'h4100_0000);
    chk("rstm_tag", 32'(bus.resp_tag), 32'd4);
    consome();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
